// File: rtl/pma_attr_checker_pkg.sv
// Configuration types for the physical-memory-attribute checker.
// Carries per-class region rule counts, bases and lengths.
package pma_attr_checker_pkg;

    localparam int unsigned NrMaxRules = 16;

    typedef struct packed {
        int unsigned                    NrNonIdempotentRules;
        logic [NrMaxRules-1:0][63:0]    NonIdempotentAddrBase;
        logic [NrMaxRules-1:0][63:0]    NonIdempotentLength;
        int unsigned                    NrExecuteRegionRules;
        logic [NrMaxRules-1:0][63:0]    ExecuteRegionAddrBase;
        logic [NrMaxRules-1:0][63:0]    ExecuteRegionLength;
        int unsigned                    NrCachedRegionRules;
        logic [NrMaxRules-1:0][63:0]    CachedRegionAddrBase;
        logic [NrMaxRules-1:0][63:0]    CachedRegionLength;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

// File: rtl/pma_attr_checker.sv
// Sequential PMA checker: scans one rule index per cycle for each region class
// and returns nonidem/exec/cached plus a fetch fault over a valid/ready channel.
module pma_attr_checker
    import pma_attr_checker_pkg::*;
#(
    parameter cva6_cfg_t   CVA6Cfg = cva6_cfg_empty,
    parameter int unsigned PLEN    = 34
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [PLEN-1:0] req_paddr_i,
    input  logic            req_is_fetch_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [PLEN-1:0] rsp_paddr_o,
    output logic            rsp_nonidem_o,
    output logic            rsp_exec_o,
    output logic            rsp_cached_o,
    output logic            rsp_fault_o,
    output logic            busy_o
);

    localparam int unsigned NrNi  = CVA6Cfg.NrNonIdempotentRules;
    localparam int unsigned NrEx  = CVA6Cfg.NrExecuteRegionRules;
    localparam int unsigned NrCa  = CVA6Cfg.NrCachedRegionRules;
    localparam int unsigned NrNe  = (NrNi > NrEx) ? NrNi : NrEx;
    localparam int unsigned N     = (NrNe > NrCa) ? NrNe : NrCa;
    localparam int unsigned IdxW  = (NrMaxRules > 1) ? $clog2(NrMaxRules) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam state_e FirstState = (N > 0) ? SCAN : RESP;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [PLEN-1:0]   paddr_q, paddr_d;
    logic              is_fetch_q, is_fetch_d;
    logic              nonidem_q, nonidem_d;
    logic              exec_q, exec_d;
    logic              cached_q, cached_d;
    logic              fault_q, fault_d;
    logic              req_ready_q, rsp_valid_q, busy_q;

    logic [63:0]       addr64;
    logic [31:0]       k;
    logic              ni_hit, ex_hit, ca_hit;

    // Region hit with a 65-bit limit so base+len never wraps.
    function automatic logic hit(input logic [63:0] addr,
                                 input logic [63:0] base,
                                 input logic [63:0] len);
        logic [64:0] lim;
        lim = {1'b0, base} + {1'b0, len};
        return (addr >= base) && ({1'b0, addr} < lim);
    endfunction

    assign addr64 = 64'(paddr_q);
    assign k      = 32'(idx_q);
    assign ni_hit = (k < NrNi) && hit(addr64, CVA6Cfg.NonIdempotentAddrBase[idx_q],
                                      CVA6Cfg.NonIdempotentLength[idx_q]);
    assign ex_hit = (k < NrEx) && hit(addr64, CVA6Cfg.ExecuteRegionAddrBase[idx_q],
                                      CVA6Cfg.ExecuteRegionLength[idx_q]);
    assign ca_hit = (k < NrCa) && hit(addr64, CVA6Cfg.CachedRegionAddrBase[idx_q],
                                      CVA6Cfg.CachedRegionLength[idx_q]);

    // Next-state and datapath updates.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        paddr_d    = paddr_q;
        is_fetch_d = is_fetch_q;
        nonidem_d  = nonidem_q;
        exec_d     = exec_q;
        cached_d   = cached_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid_i && !flush_i) begin
                    paddr_d    = req_paddr_i;
                    is_fetch_d = req_is_fetch_i;
                    nonidem_d  = 1'b0;
                    exec_d     = 1'b0;
                    cached_d   = 1'b0;
                    idx_d      = '0;
                    state_d    = FirstState;
                end
            end
            SCAN: begin
                nonidem_d = nonidem_q | ni_hit;
                exec_d    = exec_q | ex_hit;
                cached_d  = cached_q | ca_hit;
                idx_d     = idx_q + IdxW'(1);
                if (k == N - 1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush_i) begin
            state_d = IDLE;
        end

        // Fault is only meaningful alongside a response; keep it low otherwise.
        fault_d = (state_d == RESP) && is_fetch_d && !exec_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            paddr_q     <= '0;
            is_fetch_q  <= 1'b0;
            nonidem_q   <= 1'b0;
            exec_q      <= 1'b0;
            cached_q    <= 1'b0;
            fault_q     <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            paddr_q     <= paddr_d;
            is_fetch_q  <= is_fetch_d;
            nonidem_q   <= nonidem_d;
            exec_q      <= exec_d;
            cached_q    <= cached_d;
            fault_q     <= fault_d;
            req_ready_q <= (state_d == IDLE);
            rsp_valid_q <= (state_d == RESP);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign req_ready_o   = req_ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign busy_o        = busy_q;
    assign rsp_paddr_o   = paddr_q;
    assign rsp_nonidem_o = nonidem_q;
    assign rsp_exec_o    = exec_q;
    assign rsp_cached_o  = cached_q;
    assign rsp_fault_o   = fault_q;

endmodule

// File: doc/pma_attr_checker.md
# pma_attr_checker

Sequential physical-memory-attribute checker sitting directly downstream of the Sv32 MMU translation stage. It accepts one translated physical address per transaction and scans the configuration's non-idempotent, execute and cacheable region rules one rule index per cycle. It returns the three attribute bits plus an instruction-fetch fault flag over a valid/ready response channel. It replaces a fully parallel 3×NrMaxRules comparator bank with one comparator per region class.

## Interface
Parameters:
- CVA6Cfg, default cva6_cfg_empty: core configuration (cva6_cfg_t); supplies rule counts, bases and lengths.
- PLEN, default 34: physical address width (Sv32).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- flush_i  in  1  abort any in-flight transaction.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when high with req_valid_i.
- req_paddr_i  in  PLEN  physical address from the MMU.
- req_is_fetch_i  in  1  request is an instruction fetch.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  consumer takes the response.
- rsp_paddr_o  out  PLEN  latched request address.
- rsp_nonidem_o  out  1  address is in a non-idempotent region.
- rsp_exec_o  out  1  address is in an execute region.
- rsp_cached_o  out  1  address is in a cacheable region.
- rsp_fault_o  out  1  fetch outside every execute region.
- busy_o  out  1  FSM not in IDLE.

## Operation
- N = max(NrNonIdempotentRules, NrExecuteRegionRules, NrCachedRegionRules), computed at elaboration.
- FSM states are IDLE, SCAN and RESP. Rule index register idx is sized for NrMaxRules.
- **IDLE**
  - req_ready_o=1.
  - On req_valid_i&&req_ready_o: latch paddr and is_fetch, clear the three flags, set idx=0.
  - Next state is SCAN if N>0, else RESP.
- **SCAN**, per cycle for rule k=idx. The address is zero-extended to 64 bits.
  - nonidem |= (k<NrNonIdempotentRules) && hit(NonIdempotentAddrBase[k], NonIdempotentLength[k]).
  - exec and cached are updated the same way from their own rule arrays.
  - hit = (addr >= base) && ({1'b0,addr} < 65-bit(base)+len). The sum is 65 bits and never wraps.
  - idx increments each SCAN cycle. When idx==N-1, next state is RESP.
  - The scan never terminates early.
- **RESP**
  - rsp_valid_o=1; all rsp_* outputs come directly from registers and are held stable.
  - rsp_fault_o = is_fetch && !exec.
  - On rsp_ready_i, return to IDLE. A new request cannot be accepted in the same cycle.
- Zero rules of a class gives that flag 0; in particular N=0 gives exec=0 and every fetch faults.
- **flush_i**, in any state:
  - The next state is IDLE and the result is discarded; rsp_valid_o is low in the following cycle.
  - Flush beats a simultaneous req_valid_i: nothing is accepted in that cycle.
  - Flush beats a simultaneous rsp_ready_i handshake, but a response already handshaken counts as delivered.
- **Reset:** asynchronous to IDLE from any state. All outputs reset to 0 except req_ready_o=1; busy_o=0; idx=0.

## Timing
- Acceptance edge E0. For N≥1, SCAN evaluates rule k during the cycle after edge E(k), and RESP is entered at edge E(N).
- rsp_valid_o rises N+1 cycles after the acceptance cycle when N≥1, and 1 cycle after it when N=0.
- Throughput: one transaction per N+2 cycles with rsp_ready_i held high.
- req_ready_o is a pure function of state; it never depends combinationally on req_valid_i.
- No combinational path from any input to any output.

## Test plan
Configuration for all scenarios:
- NonIdem rule0: base 0x0, len 0x1000.
- Exec rule0: base 0x1_0000, len 0x1_0000. Exec rule1: base 0x8000_0000, len 0x4000_0000.
- Cached rule0: base 0x8000_0000, len 0x4000_0000.
- This gives N=2.

Scenarios:
- Fetch 0x8000_0000, rsp_ready_i=1 → rsp_valid_o 3 cycles after acceptance; exec=1, cached=1, nonidem=0, fault=0; req_ready_o back high the cycle after the handshake.
- Boundaries:
  - Fetch 0x1_FFFF → exec=1, fault=0.
  - Fetch 0x2_0000 → exec=0, fault=1.
  - Load 0xBFFF_FFFF → cached=1.
  - Load 0xC000_0000 → cached=0.
- Load 0x0FFF → nonidem=1, exec=0, fault=0 (not a fetch). Load 0x1000 → nonidem=0.
- Hold rsp_ready_i=0 for 5 cycles in RESP → all rsp_* outputs stable, req_ready_o=0 and busy_o=1 throughout; completes on the cycle rsp_ready_i rises.
- Assert flush_i during the first SCAN cycle with req_valid_i also high → IDLE next cycle, no rsp_valid_o pulse, new request not accepted until the following cycle.
- Assert rst_ni=0 asynchronously mid-SCAN → outputs at reset values immediately; the first request after release completes with correct attributes.
